// File: rtl/jt900h_mul.sv
// Radix-2 shift-add multiplier: 8x8->16 or 16x16->32, signed or unsigned.
// Optional multiply-accumulate with a signed overflow flag when JT900H_MULA_EN is defined.
module jt900h_mul (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic [15:0] op0,
  input  logic [15:0] op1,
  input  logic [31:0] acc,
  input  logic        len,
  input  logic        sign,
  input  logic        mula,
  input  logic        start,
  output logic [31:0] prod,
  output logic        busy,
  output logic        v
);

  logic        r_start_l, r_armed, r_busy, r_len, r_sign, r_neg, r_mula, r_accph, r_v;
  logic [3:0]  r_cnt;
  logic [15:0] r_m0;
  logic [31:0] r_pp, r_prod, r_acc;

  logic        w_mula, w_len, w_sign, w_launch, w_s0, w_s1, w_v;
  logic [15:0] w_m0, w_m1, w_lo;
  logic [16:0] w_add;
  logic [31:0] w_pp_nx, w_mag, w_res, w_sum;

`ifdef JT900H_MULA_EN
  assign w_mula = mula;
`else
  logic w_unused;
  assign w_mula   = 1'b0;
  assign w_unused = mula;
`endif

  assign w_len  = len  | w_mula;
  assign w_sign = sign | w_mula;
  // r_armed blocks a launch until start has been seen low after reset
  assign w_launch = cen & start & ~r_start_l & r_armed;

  always_comb begin
    w_s0 = w_len ? op0[15] : op0[7];
    w_s1 = w_len ? op1[15] : op1[7];
    if (w_len) begin
      w_m0 = (w_sign & w_s0) ? 16'(-op0) : op0;
      w_m1 = (w_sign & w_s1) ? 16'(-op1) : op1;
    end else begin
      w_m0 = {8'h00, (w_sign & w_s0) ? 8'(-op0[7:0]) : op0[7:0]};
      w_m1 = {8'h00, (w_sign & w_s1) ? 8'(-op1[7:0]) : op1[7:0]};
    end
  end

  // Upper half accumulates the multiplicand; lower half holds the unconsumed multiplier bits
  assign w_add   = {1'b0, r_pp[31:16]} + (r_pp[0] ? {1'b0, r_m0} : 17'd0);
  assign w_pp_nx = {w_add, r_pp[15:1]};
  // After 8 steps the 8x8 product sits at bits 23:8
  assign w_mag   = r_len ? w_pp_nx : {16'h0000, w_pp_nx[23:8]};
  assign w_lo    = r_neg ? 16'(-w_mag[15:0]) : w_mag[15:0];

  always_comb begin
    if (r_len) w_res = r_neg ? 32'(-w_mag) : w_mag;
    else       w_res = {r_sign ? {16{w_lo[15]}} : 16'h0000, w_lo};
  end

  assign w_sum = r_pp + r_acc;
  assign w_v   = (r_pp[31] == r_acc[31]) & (w_sum[31] != r_pp[31]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_l <= 1'b0;
      r_armed   <= 1'b0;
      r_busy    <= 1'b0;
      r_len     <= 1'b0;
      r_sign    <= 1'b0;
      r_neg     <= 1'b0;
      r_mula    <= 1'b0;
      r_accph   <= 1'b0;
      r_v       <= 1'b0;
      r_cnt     <= 4'd0;
      r_m0      <= 16'h0000;
      r_pp      <= 32'h0;
      r_prod    <= 32'h0;
      r_acc     <= 32'h0;
    end else if (cen) begin
      r_start_l <= start;
      if (!start) r_armed <= 1'b1;
      if (w_launch) begin
        r_m0    <= w_m0;
        r_pp    <= {16'h0000, w_m1};
        r_neg   <= w_sign & (w_s0 ^ w_s1);
        r_len   <= w_len;
        r_sign  <= w_sign;
        r_mula  <= w_mula;
        r_acc   <= acc;
        r_cnt   <= w_len ? 4'd0 : 4'd8;
        r_busy  <= 1'b1;
        r_accph <= 1'b0;
        r_v     <= 1'b0;
      end else if (r_busy) begin
        if (r_accph) begin
          r_prod  <= w_sum;
          r_v     <= w_v;
          r_busy  <= 1'b0;
          r_accph <= 1'b0;
        end else begin
          r_pp  <= w_pp_nx;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            // MULA parks the signed product in r_pp for one extra add cycle
            if (r_mula) begin
              r_pp    <= w_res;
              r_accph <= 1'b1;
            end else begin
              r_prod <= w_res;
              r_busy <= 1'b0;
            end
          end
        end
      end
    end
  end

  assign prod = r_prod;
  assign busy = r_busy;
  assign v    = r_v;

endmodule

// File: tb/tb_jt900h_mul.sv
// Randomized and directed checks of jt900h_mul against an arithmetic reference model.
module tb_jt900h_mul;

  logic        rst, clk, cen;
  logic [15:0] op0, op1;
  logic [31:0] acc;
  logic        len, sign, mula, start;
  logic [31:0] prod;
  logic        busy, v;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_prod;

  jt900h_mul dut (
    .rst(rst), .clk(clk), .cen(cen), .op0(op0), .op1(op1), .acc(acc),
    .len(len), .sign(sign), .mula(mula), .start(start),
    .prod(prod), .busy(busy), .v(v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic l, input logic s);
    longint x, y, p;
    logic [7:0] a8, b8;
    a8 = a[7:0];
    b8 = b[7:0];
    if (l) begin
      x = s ? longint'($signed(a)) : longint'(a);
      y = s ? longint'($signed(b)) : longint'(b);
    end else begin
      x = s ? longint'($signed(a8)) : longint'(a8);
      y = s ? longint'($signed(b8)) : longint'(b8);
    end
    p = x * y;
    return p[31:0];
  endfunction

  task automatic wait_done(input bit tog, output int ncen);
    ncen = 0;
    for (int k = 0; k < 400 && busy; k++) begin
      cen = tog ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (cen) ncen++;
    end
    cen = 1'b1;
    if (busy) chk("timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] c, input logic l, input logic s,
                        input logic m, input bit tog);
    logic [31:0] ep, p;
    logic        ev;
    int          en, n;
    bit          em;
    em = 1'b0;
`ifdef JT900H_MULA_EN
    em = m;
`endif
    if (em) begin
      p  = ref_mul(a, b, 1'b1, 1'b1);
      ep = p + c;
      ev = (p[31] == c[31]) && (ep[31] != p[31]);
      en = 17;
    end else begin
      ep = ref_mul(a, b, l, s);
      ev = 1'b0;
      en = l ? 16 : 8;
    end
    cen = 1'b1; start = 1'b0;
    tick();
    op0 = a; op1 = b; acc = c; len = l; sign = s; mula = m; start = 1'b1;
    tick();
    chk({tag, "/launch_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "/hold_prod"}, prod, last_prod);
    wait_done(tog, n);
    chk({tag, "/cycles"}, 32'(n), 32'(en));
    chk({tag, "/prod"}, prod, ep);
    chk({tag, "/v"}, {31'd0, v}, {31'd0, ev});
    last_prod = ep;
    repeat (2) tick();
    chk({tag, "/one_launch"}, {31'd0, busy}, 32'd0);
    start = 1'b0;
  endtask

  initial begin
    int n;
    logic [15:0] pool [6];
    pool = '{16'h0000, 16'h8000, 16'hFFFF, 16'h0080, 16'h007F, 16'h7FFF};
    rst = 1'b1; cen = 1'b1; start = 1'b1;
    op0 = '0; op1 = '0; acc = '0; len = 1'b0; sign = 1'b0; mula = 1'b0;
    last_prod = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst/prod", prod, 32'h0);
    chk("rst/busy", {31'd0, busy}, 32'd0);
    chk("rst/v", {31'd0, v}, 32'd0);
    #2 rst = 1'b0;
    repeat (3) tick();
    chk("rst/start_high_no_launch", {31'd0, busy}, 32'd0);
    start = 1'b0;

    run_op("u16_ffff", 16'hFFFF, 16'hFFFF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("u16_ffff/const", prod, 32'hFFFE0001);
    run_op("s8_80x7f", 16'h0080, 16'h007F, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("s8_80x7f/const", prod, 32'hFFFFC080);
    run_op("s16_8000sq", 16'h8000, 16'h8000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("s16_8000sq/const", prod, 32'h40000000);
    run_op("zero", 16'h0000, 16'h1234, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("u16_cen_toggle", 16'hFFFF, 16'hFFFF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("u16_cen_toggle/const", prod, 32'hFFFE0001);
    run_op("mula_ignored_or_used", 16'h00F3, 16'h0011, 32'h1, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef JT900H_MULA_EN
    run_op("mula_ovf", 16'h7FFF, 16'h7FFF, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("mula_ovf/const", prod, 32'hBFFF0000);
    chk("mula_ovf/vconst", {31'd0, v}, 32'd1);
    run_op("mula_acc0", 16'h7FFF, 16'h7FFF, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("mula_acc0/const", prod, 32'h3FFF0001);
`endif

    // reset pulsed mid-operation
    cen = 1'b1; start = 1'b0; tick();
    op0 = 16'h1234; op1 = 16'h5678; len = 1'b1; sign = 1'b0; mula = 1'b0; start = 1'b1;
    tick();
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    chk("rst_mid/busy", {31'd0, busy}, 32'd0);
    chk("rst_mid/prod", prod, 32'h0);
    #1 rst = 1'b0;
    last_prod = 32'h0;
    start = 1'b0;
    run_op("after_rst", 16'h00FF, 16'h0101, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // relaunch at iteration 10 with 2x3
    cen = 1'b1; start = 1'b0; tick();
    op0 = 16'hFFFF; op1 = 16'hFFFF; len = 1'b1; sign = 1'b0; mula = 1'b0; start = 1'b1;
    tick();
    repeat (10) tick();
    start = 1'b0; tick();
    op0 = 16'd2; op1 = 16'd3; start = 1'b1;
    tick();
    repeat (8) tick();
    chk("abort/old_prod_kept", prod, last_prod);
    chk("abort/still_busy", {31'd0, busy}, 32'd1);
    wait_done(1'b0, n);
    chk("abort/cycles", 32'(n), 32'd8);
    chk("abort/prod", prod, 32'd6);
    last_prod = 32'd6;
    start = 1'b0;

    for (int i = 0; i < 30; i++) begin
      logic [15:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : 16'($urandom);
      run_op($sformatf("rnd%0d", i), a, b, $urandom, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jt900h_mul.md
JT900H_MUL -- requirements
Module: jt900h_mul

Interface
REQ-001 rst  input  1  reset, asynchronous, active-high.
REQ-002 clk  input  1  single clock; all state on posedge clk.
REQ-003 cen  input  1  clock enable; qualifies every register update except reset.
REQ-004 op0  input  16  multiplicand; len=0 uses op0[7:0].
REQ-005 op1  input  16  multiplier; len=0 uses op1[7:0].
REQ-006 acc  input  32  accumulator addend for MULA; ignored otherwise.
REQ-007 len  input  1  0 = 8x8 to 16 bits, 1 = 16x16 to 32 bits.
REQ-008 sign  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 mula  input  1  1 = multiply-accumulate request.
REQ-010 start  input  1  operation request; acts on rising edge only.
REQ-011 prod  output  32  result register.
REQ-012 busy  output  1  high while an operation is in progress.
REQ-013 v  output  1  MULA signed overflow flag.

Function
REQ-014 Start detection: start is registered as start_l on cen cycles; start=1 with start_l=0 on a cen cycle is a launch.
REQ-015 Launch loads these values:
- operand magnitudes: absolute values when sign=1 and the operand sign bit is set (bit 15 for len=1, bit 7 for len=0); otherwise raw values.
- result sign: sign & (s0^s1).
- partial product: 0.
- iteration counter: 0 for len=1, 8 for len=0 (4-bit counter).
- outputs: busy=1, v=0; prod keeps its previous value until completion.
REQ-016 Iteration: on each cen cycle while busy, the block adds the multiplicand magnitude to the upper partial product when the multiplier LSB is 1, then shifts right 1 bit (shift-add, radix 2). The counter increments.
REQ-017 Completion: the iteration with counter=15 writes prod, clears busy and ends the operation. busy is high for exactly 16 (len=1) or 8 (len=0) cen cycles after the launch cycle.
REQ-018 Final value: prod = negated magnitude when the result sign is set, else the magnitude.
REQ-019 len=0 upper half: prod[31:16] = sign-extension of prod[15] when sign=1, else zero.
REQ-020 A launch while busy aborts the current operation and restarts with the new operands; prod is not updated by the aborted operation.
REQ-021 start held high produces exactly one launch; a new launch needs start to return low on a cen cycle.
REQ-022 cen=0 freezes all state, including start_l, the counter and busy.
REQ-023 0x0000 operands give prod=0. The most-negative operand is handled through its unsigned magnitude 0x8000 or 0x80.

Reset
REQ-024 rst=1 asynchronously clears prod, busy, v, start_l, the counter and all internal registers to 0, including when it arrives mid-operation.
REQ-025 After rst falls, a start already high produces no launch until it has been seen low.

Configuration
REQ-026 Macro JT900H_MULA_EN: when defined, mula=1 at launch forces sign=1 and len=1. A 17th busy cycle then sets prod = product + acc (32-bit wrap). The same cycle sets v=1 when the addends share a sign bit and the sum's sign bit differs from it, else v=0.
REQ-027 Without JT900H_MULA_EN: mula and acc are ignored, v is constant 0, and the ports remain present.

Verification
REQ-028 Unsigned 16-bit: len=1, sign=0, op0=0xFFFF, op1=0xFFFF -> busy 16 cen cycles, prod=0xFFFE0001.
REQ-029 Signed 8-bit: len=0, sign=1, op0=0x0080, op1=0x007F -> busy 8 cycles, prod=0xFFFFC080.
REQ-030 Signed 16-bit, negative times negative: op0=0x8000, op1=0x8000, len=1, sign=1 -> prod=0x40000000.
REQ-031 MULA, macro defined: op0=0x7FFF, op1=0x7FFF, acc=0x7FFFFFFF -> busy 17 cycles, prod=0xBFFF0000, v=1.
   Same operands with acc=0 -> prod=0x3FFF0001, v=0.
REQ-032 Stall and abort:
- cen toggling 50% during a len=1 operation -> result matches REQ-028 after 16 cen-high cycles.
- rst pulsed at iteration 5 -> busy=0, prod=0 immediately.
- relaunch at iteration 10 with 2x3 -> prod=6 only.
